demo_scene_sequencer: RTL

//  Frame-rate controller that sequences the demo through NUM_SCENES scenes and configures the wave renderer per scene.

---
 rtl/demo_pkg.sv | 25 ++
 rtl/demo_scene_rom.sv | 36 +++
 rtl/demo_scene_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/demo_pkg.sv
// Shared types and constants for the demo scene sequencer and its scene ROM.
package demo_pkg;

  localparam int NUM_SCENES = 4;
  localparam int NUM_WAVES  = 3;
  localparam int FADE_BITS  = 4;
  localparam int SCENE_BITS = $clog2(NUM_SCENES);

  // Full brightness; fade counts 0..FADE_MAX.
  localparam logic [FADE_BITS-1:0] FADE_MAX = FADE_BITS'(2**FADE_BITS - 1);

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    HOLD     = 2'd1,
    FADE_OUT = 2'd2
  } scene_state_t;

  // Per-scene renderer configuration; wave i occupies bits [2i+1:2i].
  typedef struct packed {
    logic [NUM_WAVES-1:0][1:0] wave_freq_shl;
    logic [1:0]                palette_sel;
    logic [2:0]                speed_shl;
  } scene_cfg_t;

endpackage

// File: rtl/demo_scene_rom.sv
// Constant table mapping a scene index to its renderer configuration.
module demo_scene_rom
  import demo_pkg::*;
(
  input  logic [SCENE_BITS-1:0] scene_idx,
  output scene_cfg_t            cfg
);

  // Purely combinational lookup; the sequencer registers the result.
  always_comb begin
    cfg = '0;
    case (scene_idx)
      SCENE_BITS'(0): begin
        cfg.wave_freq_shl = 6'b10_01_00;
        cfg.palette_sel   = 2'd0;
        cfg.speed_shl     = 3'd1;
      end
      SCENE_BITS'(1): begin
        cfg.wave_freq_shl = 6'b01_11_01;
        cfg.palette_sel   = 2'd1;
        cfg.speed_shl     = 3'd2;
      end
      SCENE_BITS'(2): begin
        cfg.wave_freq_shl = 6'b11_00_10;
        cfg.palette_sel   = 2'd2;
        cfg.speed_shl     = 3'd3;
      end
      default: begin
        cfg.wave_freq_shl = 6'b00_10_11;
        cfg.palette_sel   = 2'd3;
        cfg.speed_shl     = 3'd5;
      end
    endcase
  end

endmodule

// File: rtl/demo_scene_sequencer.sv
// Frame-rate scene sequencer: fades each scene in, holds it, fades it out,
// then advances to the next scene and loads its renderer configuration.
module demo_scene_sequencer
  import demo_pkg::*;
#(
  parameter int HOLD_FRAMES     = 240,
  parameter int SCENE_TIME_BITS = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_frame,
  input  logic                       pause,
  input  logic                       skip,
  output logic [SCENE_BITS-1:0]      scene,
  output logic [FADE_BITS-1:0]       fade,
  output logic [2*NUM_WAVES-1:0]     wave_freq_shl,
  output logic [1:0]                 palette_sel,
  output logic [2:0]                 speed_shl,
  output logic [SCENE_TIME_BITS-1:0] scene_time,
  output logic                       cfg_update
);

  localparam int HOLD_BITS = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_BITS-1:0]  HOLD_LAST  = HOLD_BITS'(HOLD_FRAMES - 1);
  localparam logic [SCENE_BITS-1:0] SCENE_LAST = SCENE_BITS'(NUM_SCENES - 1);

  scene_state_t                state_q, state_d;
  logic [FADE_BITS-1:0]        fade_q, fade_d;
  logic [HOLD_BITS-1:0]        hold_cnt_q, hold_cnt_d;
  logic [SCENE_BITS-1:0]       scene_q, scene_d;
  logic [SCENE_TIME_BITS-1:0]  scene_time_q, scene_time_d;
  logic                        skip_pending_q, skip_pending_d;
  logic                        cfg_update_q, cfg_update_d;
  scene_cfg_t                  cfg_q, cfg_d;

  logic [SCENE_BITS-1:0]       rom_idx;
  scene_cfg_t                  rom_cfg;
  logic                        step;
  logic                        skip_any;

  demo_scene_rom u_rom (
    .scene_idx (rom_idx),
    .cfg       (rom_cfg)
  );

  // A skip arriving with the frame strobe acts on that same frame.
  assign step     = new_frame & ~pause;
  assign skip_any = skip_pending_q | skip;

  // Next-state logic: one FSM step per unpaused frame, skip latch otherwise.
  always_comb begin
    state_d        = state_q;
    fade_d         = fade_q;
    hold_cnt_d     = hold_cnt_q;
    scene_d        = scene_q;
    scene_time_d   = scene_time_q;
    skip_pending_d = skip_any;
    cfg_update_d   = 1'b0;
    if (step) begin
      scene_time_d = scene_time_q + SCENE_TIME_BITS'(1);
      case (state_q)
        FADE_IN: begin
          if (skip_any) begin
            state_d        = FADE_OUT;
            skip_pending_d = 1'b0;
          end else if (fade_q == FADE_MAX) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end else begin
            fade_d = fade_q + FADE_BITS'(1);
          end
        end
        HOLD: begin
          fade_d = FADE_MAX;
          if (skip_any || hold_cnt_q == HOLD_LAST) begin
            state_d        = FADE_OUT;
            skip_pending_d = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_BITS'(1);
          end
        end
        FADE_OUT: begin
          // Switch scenes only at black so the config change is invisible.
          if (fade_q == '0) begin
            scene_d      = (scene_q == SCENE_LAST) ? '0 : scene_q + SCENE_BITS'(1);
            scene_time_d = '0;
            cfg_update_d = 1'b1;
            state_d      = FADE_IN;
          end else begin
            fade_d = fade_q - FADE_BITS'(1);
          end
        end
        default: begin
          state_d = FADE_IN;
          fade_d  = '0;
        end
      endcase
    end
  end

  // The ROM is addressed with the scene about to be registered, so reset
  // and scene switches both load the matching configuration.
  always_comb begin
    rom_idx = reset ? '0 : scene_d;
    cfg_d   = (reset || cfg_update_d) ? rom_cfg : cfg_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    cfg_q <= cfg_d;
    if (reset) begin
      state_q        <= FADE_IN;
      fade_q         <= '0;
      hold_cnt_q     <= '0;
      scene_q        <= '0;
      scene_time_q   <= '0;
      skip_pending_q <= 1'b0;
      cfg_update_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      fade_q         <= fade_d;
      hold_cnt_q     <= hold_cnt_d;
      scene_q        <= scene_d;
      scene_time_q   <= scene_time_d;
      skip_pending_q <= skip_pending_d;
      cfg_update_q   <= cfg_update_d;
    end
  end

  assign scene         = scene_q;
  assign fade          = fade_q;
  assign wave_freq_shl = cfg_q.wave_freq_shl;
  assign palette_sel   = cfg_q.palette_sel;
  assign speed_shl     = cfg_q.speed_shl;
  assign scene_time    = scene_time_q;
  assign cfg_update    = cfg_update_q;

endmodule
